// File: rtl/sha256_pkg.sv
// SHA-256 constants, word/state types and round helper functions.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sha256_pkg;

    typedef logic [31:0] word_t;
    // Working/chaining state a..h; index 0 (a / H0) sits in the most significant word.
    typedef logic [0:7][31:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ctrl_state_t;

    localparam state_t H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round, purely combinational.
// Latency: 0 cycles.
// Backpressure: none; the caller decides when to register the result.
//   cur_state : a..h before the round
//   kt, wt    : round constant and schedule word
//   nxt_state : a..h after the round
module sha256_round
    import sha256_pkg::*;
(
    input  state_t cur_state,
    input  word_t  kt,
    input  word_t  wt,
    output state_t nxt_state
);

    word_t t1;
    word_t t2;

    assign t1 = cur_state[7] + big_sigma1(cur_state[4])
              + ch(cur_state[4], cur_state[5], cur_state[6]) + kt + wt;
    assign t2 = big_sigma0(cur_state[0]) + maj(cur_state[0], cur_state[1], cur_state[2]);

    assign nxt_state = {t1 + t2, cur_state[0], cur_state[1], cur_state[2],
                        cur_state[3] + t1, cur_state[4], cur_state[5], cur_state[6]};

endmodule

// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression of one 512-bit block, ROUNDS_PER_CYCLE rounds per clock.
// Latency: out_valid rises 64/ROUNDS_PER_CYCLE cycles after the accept edge.
// Backpressure: digest held in DONE until out_ready; in_ready depends on out_ready, never on in_valid.
//   in_valid/in_ready/in_first/in_redo/in_block : block input handshake and per-block controls
//   out_valid/out_ready/out_digest              : digest output handshake
//   busy                                        : core not idle
module sha256_iter_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic         in_redo,
    input  logic [511:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest,
    output logic         busy
);

    localparam int NUM_CYC = 64 / ROUNDS_PER_CYCLE;
    localparam logic [5:0] LAST_CNT = 6'(NUM_CYC - 1);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rounds
        $error("sha256_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    ctrl_state_t state_q, state_d;
    logic [5:0]  cnt_q;
    logic        redo_q;
    logic        accept;
    state_t      chain_h;
    state_t      work_q;
    state_t      round_out;
    state_t      block_sum;
    word_t       w_q    [0:15];
    word_t       w_next [0:15];
    logic [5:0]  k_base;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = !reset;
                if (in_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == LAST_CNT) state_d = ST_DONE;
            end
            ST_DONE: begin
                in_ready = out_ready && !reset;
                if (out_ready) state_d = in_valid ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign busy   = (state_q != ST_IDLE);

    // ---------------- unrolled round chain ----------------
    assign k_base = cnt_q * 6'(ROUNDS_PER_CYCLE);

    for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_rnd
        state_t s_in;
        state_t s_out;
        if (i == 0) begin : g_first
            assign s_in = work_q;
        end else begin : g_chain
            assign s_in = g_rnd[i-1].s_out;
        end
        sha256_round u_round (
            .cur_state (s_in),
            .kt        (K[k_base + 6'(i)]),
            .wt        (w_q[i]),
            .nxt_state (s_out)
        );
    end

    assign round_out = g_rnd[ROUNDS_PER_CYCLE-1].s_out;

    // ---------------- message expansion ----------------
    // Extended window: entries 0..15 are the current W window, 16.. are the next
    // ROUNDS_PER_CYCLE schedule words, each of which may depend on earlier new ones.
    for (genvar i = 0; i < 16 + ROUNDS_PER_CYCLE; i++) begin : g_ext
        word_t v;
        if (i < 16) begin : g_cur
            assign v = w_q[i];
        end else begin : g_new
            assign v = small_sigma1(g_ext[i-2].v) + g_ext[i-7].v
                     + small_sigma0(g_ext[i-15].v) + g_ext[i-16].v;
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_shift
        assign w_next[k] = g_ext[ROUNDS_PER_CYCLE + k].v;
    end

    always_comb begin
        block_sum = '0;
        for (int i = 0; i < 8; i++) block_sum[i] = chain_h[i] + round_out[i];
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            chain_h    <= H0;
            work_q     <= '0;
            w_q        <= '{default: '0};
            cnt_q      <= '0;
            redo_q     <= 1'b0;
            out_valid  <= 1'b0;
            out_digest <= '0;
        end else if (accept) begin
            for (int i = 0; i < 16; i++) w_q[i] <= in_block[511 - 32*i -: 32];
            redo_q    <= in_redo;
            work_q    <= in_first ? H0 : chain_h;
            if (in_first) chain_h <= H0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
        end else if (state_q == ST_RUN) begin
            work_q <= round_out;
            w_q    <= w_next;
            cnt_q  <= cnt_q + 6'd1;
            if (cnt_q == LAST_CNT) begin
                out_digest <= block_sum;
                if (!redo_q) chain_h <= block_sum;
                out_valid  <= 1'b1;
            end
        end else if (state_q == ST_DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sha256_iter_core.sv
// Self-checking bench for sha256_iter_core: known-answer digests, latency, chaining, redo, stall, reset.
// Latency: n/a.
// Backpressure: exercised through out_ready stalls and back-to-back accepts.
module tb_sha256_iter_core;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] B1_BLK    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B2_BLK    = {448'h0, 32'h0, 32'h000001c0};
    localparam logic [255:0] ABC_D   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_D = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO_D   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk;
    logic         reset;
    logic         in_valid, in_ready, in_first, in_redo;
    logic [511:0] in_block;
    logic         out_valid, out_ready, busy;
    logic [255:0] out_digest;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [255:0] dig;
        bit           chk;
        int           acc;
    } exp_t;
    exp_t exp_q[$];

    sha256_iter_core #(.ROUNDS_PER_CYCLE(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_first   (in_first),
        .in_redo    (in_redo),
        .in_block   (in_block),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_digest (out_digest),
        .busy       (busy)
    );

    // Unroll-factor sweep: one instance per legal ROUNDS_PER_CYCLE, shared stimulus.
    logic         sw_valid;
    logic [511:0] sw_block;
    logic         sw_ir   [5];
    logic         sw_ov   [5];
    logic         sw_busy [5];
    logic [255:0] sw_dig  [5];

    for (genvar g = 0; g < 5; g++) begin : g_sw
        sha256_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_sw (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (sw_valid),
            .in_ready   (sw_ir[g]),
            .in_first   (1'b1),
            .in_redo    (1'b0),
            .in_block   (sw_block),
            .out_valid  (sw_ov[g]),
            .out_ready  (1'b1),
            .out_digest (sw_dig[g]),
            .busy       (sw_busy[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, latency measured at out_valid rise.
    logic ov_prev  = 1'b0;
    int   rise_cyc = 0;
    always @(negedge clk) begin
        if (reset) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                rise_cyc = cyc;
                if (exp_q.size() == 0) check_eq("spurious_out_valid", 256'(out_valid), 256'(0));
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk) check_eq("digest", out_digest, e.dig);
                check_eq("latency", 256'(rise_cyc - e.acc), 256'(64));
            end
            ov_prev = out_valid;
        end
    end

    // Offers a block and waits (bounded) for acceptance; inputs are scrambled afterwards
    // so that anything sampled outside the accept edge would corrupt the result.
    task automatic send(input logic [511:0] blk, input logic first, input logic redo,
                        input logic [255:0] exp, input bit chk, input bit sync);
        int t;
        exp_t e;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_block = blk;
        in_first = first;
        in_redo  = redo;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", 256'(in_ready), 256'(1));
        end else begin
            e.dig = exp;
            e.chk = chk;
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = ~first;
        in_redo  = ~redo;
        in_block = ~blk;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() > 0) check_eq("drain_timeout", 256'(exp_q.size()), 256'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lat [5];
        logic [255:0] dg [5];
        int sw_acc;
        int ov_seen;

        reset = 1'b1;
        in_valid = 1'b0; in_first = 1'b0; in_redo = 1'b0; in_block = '0;
        out_ready = 1'b1;
        sw_valid = 1'b0; sw_block = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 256'(in_ready), 256'(0));
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready_after", 256'(in_ready), 256'(1));
        check_eq("rst_out_valid", 256'(out_valid), 256'(0));
        check_eq("rst_out_digest", out_digest, 256'(0));
        check_eq("rst_busy", 256'(busy), 256'(0));

        // Empty message across all unroll factors
        @(posedge clk); #1;
        sw_valid = 1'b1;
        sw_block = EMPTY_BLK;
        @(negedge clk);
        for (int g = 0; g < 5; g++) check_eq($sformatf("sweep_ready_R%0d", 1 << g), 256'(sw_ir[g]), 256'(1));
        sw_acc = cyc + 1;
        @(posedge clk); #1;
        sw_valid = 1'b0;
        sw_block = '1;
        for (int g = 0; g < 5; g++) begin
            lat[g] = -1;
            dg[g]  = '0;
        end
        for (int t = 0; t < 70; t++) begin
            @(negedge clk);
            for (int g = 0; g < 5; g++) begin
                if (sw_ov[g] && lat[g] < 0) begin
                    lat[g] = cyc - sw_acc;
                    dg[g]  = sw_dig[g];
                end
            end
        end
        for (int g = 0; g < 5; g++) begin
            check_eq($sformatf("sweep_lat_R%0d", 1 << g), 256'(lat[g]), 256'(64 >> g));
            check_eq($sformatf("sweep_dig_R%0d", 1 << g), dg[g], EMPTY_D);
        end

        // "abc"
        send(ABC_BLK, 1'b1, 1'b0, ABC_D, 1'b1, 1'b1);
        drain();

        // Two-block message, second block back-to-back
        send(B1_BLK, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        send(B2_BLK, 1'b0, 1'b0, TWO_D, 1'b1, 1'b1);
        drain();

        // Redo: three uncommitted digests, then a committed one from the same chain
        send(B1_BLK, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) send(B2_BLK, 1'b0, 1'b1, TWO_D, 1'b1, 1'b1);
        send(B2_BLK, 1'b0, 1'b0, TWO_D, 1'b1, 1'b1);
        drain();

        // First + redo: chain restarts from H0 and stays there
        send(ABC_BLK, 1'b1, 1'b1, ABC_D, 1'b1, 1'b1);
        send(ABC_BLK, 1'b0, 1'b0, ABC_D, 1'b1, 1'b1);
        drain();

        // Stall in DONE for 10 cycles, then back-to-back accept
        out_ready = 1'b0;
        send(ABC_BLK, 1'b1, 1'b0, ABC_D, 1'b1, 1'b1);
        for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
        check_eq("stall_ov_rise", 256'(out_valid), 256'(1));
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check_eq("stall_ov_hold", 256'(out_valid), 256'(1));
            check_eq("stall_dig_hold", out_digest, ABC_D);
            check_eq("stall_in_ready", 256'(in_ready), 256'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(EMPTY_BLK, 1'b1, 1'b0, EMPTY_D, 1'b1, 1'b0);
        check_eq("b2b_ov_low", 256'(out_valid), 256'(0));
        drain();

        // Reset mid-RUN on a chained block; nothing emitted, chain back to H0
        send(B1_BLK, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        drain();
        @(posedge clk); #1;
        in_valid = 1'b1; in_block = B2_BLK; in_first = 1'b0; in_redo = 1'b0;
        @(negedge clk);
        check_eq("rst_run_accept", 256'(in_ready), 256'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        ov_seen = 0;
        for (int t = 0; t < 70; t++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check_eq("rst_run_no_ov", 256'(ov_seen), 256'(0));
        send(ABC_BLK, 1'b0, 1'b0, ABC_D, 1'b1, 1'b1);
        drain();

        check_eq("scoreboard_empty", 256'(exp_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
